// File: rtl/alu_pipe_pkg.sv
// Shared pipeline types for the integer execution units.
// alu_op_e is 4 bits wide; codes 0..4 are fixed by existing consumers.
package pipeline_types;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_pipe_core.sv
// Stateless integer op evaluation; undefined encodings yield zero.
module alu_core
  import pipeline_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [XLEN-1:0]     result_o
);

  localparam int SHW = $clog2(XLEN);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [SHW-1:0]  shamt;

  assign a_s   = a_i;
  assign b_s   = b_i;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned(a_s >>> shamt);
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Elastic ALU pipeline: result computed at issue, then carried through
// STAGES registers with per-stage hold/advance and bubble collapsing.
module alu_pipe
  import pipeline_types::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_TAG_W = 4,
  parameter int PREG_W    = 6,
  parameter int STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [ALU_OP_W-1:0]  alu_op_i,
  input  logic [XLEN-1:0]      op1_i,
  input  logic [XLEN-1:0]      op2_i,
  input  logic [PREG_W-1:0]    rd_p_i,
  input  logic [ROB_TAG_W-1:0] rob_tag_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic [PREG_W-1:0]    rd_p_o,
  output logic [ROB_TAG_W-1:0] rob_tag_o
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("alu_pipe: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic                 vld;
    logic [XLEN-1:0]      result;
    logic [PREG_W-1:0]    rd_p;
    logic [ROB_TAG_W-1:0] rob_tag;
  } stage_t;

  stage_t [STAGES-1:0] stg_q;
  stage_t [STAGES:0]   stg_in;
  stage_t              new_stg;
  logic   [STAGES-1:0] vld;
  logic   [STAGES-1:0] adv;
  logic   [XLEN-1:0]   alu_res;
  logic                issue;

  alu_core #(.XLEN(XLEN)) u_core (
    .op_i     (alu_op_i),
    .a_i      (op1_i),
    .b_i      (op2_i),
    .result_o (alu_res)
  );

  assign ready_o = adv[0] && !flush_i;
  assign issue   = valid_i && ready_o;

  always_comb begin
    new_stg         = '0;
    new_stg.vld     = issue;
    new_stg.result  = alu_res;
    new_stg.rd_p    = rd_p_i;
    new_stg.rob_tag = rob_tag_i;
  end

  // stg_in[k] is what stage k would capture: the new issue for k=0,
  // otherwise the contents of stage k-1.
  assign stg_in = {stg_q, new_stg};

  // Stage k may advance when the tail drains or any stage at or beyond k
  // is empty, which is what lets bubbles collapse under a stalled tail.
  always_comb begin
    vld = '0;
    adv = '0;
    for (int k = 0; k < STAGES; k++) vld[k] = stg_q[k].vld;
    for (int k = 0; k < STAGES; k++) adv[k] = ready_i || (|((~vld) >> k));
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst || flush_i) begin
        stg_q[k].vld <= 1'b0;
      end else if (adv[k]) begin
        stg_q[k].vld <= stg_in[k].vld;
      end
      if (rst) begin
        if (k == STAGES-1) begin
          stg_q[k].result  <= '0;
          stg_q[k].rd_p    <= '0;
          stg_q[k].rob_tag <= '0;
        end
      end else if (!flush_i && adv[k] && stg_in[k].vld) begin
        stg_q[k].result  <= stg_in[k].result;
        stg_q[k].rd_p    <= stg_in[k].rd_p;
        stg_q[k].rob_tag <= stg_in[k].rob_tag;
      end
    end
  end

  assign valid_o   = stg_q[STAGES-1].vld;
  assign result_o  = stg_q[STAGES-1].result;
  assign rd_p_o    = stg_q[STAGES-1].rd_p;
  assign rob_tag_o = stg_q[STAGES-1].rob_tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: op results, stall/ordering, flush, reset,
// and 1-op/cycle throughput at STAGES=1, 2 and 4.
module tb_alu_pipe;
  import pipeline_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  alu_op_i;
  logic [31:0] op1_i, op2_i;
  logic [5:0]  rd_p_i;
  logic [3:0]  rob_tag_i;
  logic        flush_i;
  logic        ready_i;
  logic        aux_rdy;

  logic        ready_o, valid_o;
  logic [31:0] result_o;
  logic [5:0]  rd_p_o;
  logic [3:0]  rob_tag_o;

  logic        r1_o, v1_o, r4_o, v4_o;
  logic [31:0] res1_o, res4_o;
  logic [5:0]  rd1_o, rd4_o;
  logic [3:0]  tag1_o, tag4_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(32), .ROB_TAG_W(4), .PREG_W(6), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .op1_i(op1_i), .op2_i(op2_i), .rd_p_i(rd_p_i),
    .rob_tag_i(rob_tag_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .rd_p_o(rd_p_o),
    .rob_tag_o(rob_tag_o)
  );

  alu_pipe #(.XLEN(32), .ROB_TAG_W(4), .PREG_W(6), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(r1_o),
    .alu_op_i(alu_op_i), .op1_i(op1_i), .op2_i(op2_i), .rd_p_i(rd_p_i),
    .rob_tag_i(rob_tag_i), .flush_i(flush_i), .valid_o(v1_o),
    .ready_i(aux_rdy), .result_o(res1_o), .rd_p_o(rd1_o),
    .rob_tag_o(tag1_o)
  );

  alu_pipe #(.XLEN(32), .ROB_TAG_W(4), .PREG_W(6), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(r4_o),
    .alu_op_i(alu_op_i), .op1_i(op1_i), .op2_i(op2_i), .rd_p_i(rd_p_i),
    .rob_tag_i(rob_tag_i), .flush_i(flush_i), .valid_o(v4_o),
    .ready_i(aux_rdy), .result_o(res4_o), .rd_p_o(rd4_o),
    .rob_tag_o(tag4_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag, input logic [5:0] rd);
    valid_i   = v;
    alu_op_i  = op;
    op1_i     = a;
    op2_i     = b;
    rob_tag_i = tag;
    rd_p_i    = rd;
  endtask

  // Issue one op into an empty, unstalled STAGES=2 pipe and check its result.
  task automatic exec(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    drive(1'b1, op, a, b, 4'd1, 6'd1);
    step();
    valid_i = 1'b0;
    step();
    #1;
    chk({tag, "_vld"}, valid_o, 1);
    chk({tag, "_res"}, result_o, exp);
  endtask

  task automatic thr_chk(input string tag, input int s, input int c, input logic v,
                         input logic [3:0] t, input logic [31:0] r);
    int idx;
    idx = c - s + 1;
    chk({tag, "_vld"}, v, (idx >= 0 && idx < 8) ? 1 : 0);
    if (idx >= 0 && idx < 8) begin
      chk({tag, "_tag"}, t, idx + 1);
      chk({tag, "_res"}, r, 2 * (idx + 1));
    end
  endtask

  initial begin
    int nxt;
    int exp_tag;
    logic acc;

    rst = 1'b1; flush_i = 1'b0; ready_i = 1'b1; aux_rdy = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 6'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_result_o", result_o, 0);

    // First op: latency and sideband
    drive(1'b1, ALU_ADD, 32'd7, 32'd5, 4'd3, 6'd9);
    step();
    valid_i = 1'b0;
    #1;
    chk("add_early_vld", valid_o, 0);
    step();
    #1;
    chk("add_vld", valid_o, 1);
    chk("add_res", result_o, 32'd12);
    chk("add_tag", rob_tag_o, 4'd3);
    chk("add_rd", rd_p_o, 6'd9);
    step();
    #1;
    chk("add_drained", valid_o, 0);

    exec("sub_wrap", ALU_SUB,  32'd0,        32'd1,        32'hFFFF_FFFF);
    exec("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'd2,       32'd1);
    exec("sra",      ALU_SRA,  32'h8000_0000, 32'd35,      32'hF000_0000);
    exec("srl",      ALU_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000);
    exec("sll",      ALU_SLL,  32'd1,        32'd33,       32'd2);
    exec("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1);
    exec("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0);
    exec("and",      ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    exec("or",       ALU_OR,   32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
    exec("xor",      ALU_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
    exec("undef",    4'd15,    32'd7,        32'd5,        32'd0);
    step();

    // Stall: ready_i low while streaming 6 ops
    ready_i = 1'b0;
    drive(1'b1, ALU_ADD, 32'd10, 32'd0, 4'd1, 6'd1);
    step();
    drive(1'b1, ALU_ADD, 32'd20, 32'd0, 4'd2, 6'd2);
    #1;
    chk("stall_rdy_one", ready_o, 1);
    step();
    drive(1'b1, ALU_ADD, 32'd30, 32'd0, 4'd3, 6'd3);
    #1;
    chk("stall_rdy_full", ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("stall_rdy_hold", ready_o, 0);
      chk("stall_vld_hold", valid_o, 1);
      chk("stall_tag_hold", rob_tag_o, 4'd1);
      chk("stall_res_hold", result_o, 32'd10);
    end
    ready_i = 1'b1;
    #1;
    nxt = 2;
    exp_tag = 1;
    for (int c = 0; c < 40 && exp_tag <= 6; c++) begin
      if (valid_o) begin
        chk("order_tag", rob_tag_o, exp_tag);
        chk("order_res", result_o, 10 * exp_tag);
        exp_tag++;
      end
      acc = valid_i && ready_o;
      step();
      if (acc) begin
        nxt++;
        if (nxt < 6) drive(1'b1, ALU_ADD, 10 * (nxt + 1), 32'd0, nxt + 1, nxt + 1);
        else valid_i = 1'b0;
      end
      #1;
    end
    chk("stall_all_done", exp_tag, 7);
    step(); step();
    chk("stall_no_dup", valid_o, 0);

    // Flush with a simultaneous issue
    ready_i = 1'b0;
    drive(1'b1, ALU_ADD, 32'd1, 32'd1, 4'd7, 6'd7);
    step();
    drive(1'b1, ALU_ADD, 32'd2, 32'd2, 4'd8, 6'd8);
    step();
    drive(1'b1, ALU_ADD, 32'd3, 32'd3, 4'd9, 6'd9);
    flush_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("flush_rdy", ready_o, 0);
    chk("flush_vld_pre", valid_o, 1);
    chk("flush_tag_pre", rob_tag_o, 4'd7);
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("flush_vld_post", valid_o, 0);
    chk("flush_rdy_post", ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_compl", valid_o, 0);
    end

    // Reset with a full, stalled pipe
    ready_i = 1'b0;
    drive(1'b1, ALU_ADD, 32'd5, 32'd6, 4'd5, 6'd5);
    step();
    drive(1'b1, ALU_ADD, 32'd6, 32'd6, 4'd6, 6'd6);
    step();
    valid_i = 1'b0;
    #1;
    chk("rstmid_full", valid_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("rstmid_vld", valid_o, 0);
    chk("rstmid_res", result_o, 0);
    chk("rstmid_tag", rob_tag_o, 0);
    chk("rstmid_rd", rd_p_o, 0);
    chk("rstmid_rdy", ready_o, 1);
    step();
    chk("rstmid_no_compl", valid_o, 0);

    // Back-to-back throughput at STAGES 1, 2, 4
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) drive(1'b1, ALU_ADD, c + 1, c + 1, c + 1, c + 1);
      else valid_i = 1'b0;
      #1;
      if (c < 8) begin
        chk("thr_rdy1", r1_o, 1);
        chk("thr_rdy2", ready_o, 1);
        chk("thr_rdy4", r4_o, 1);
      end
      step();
      thr_chk("thr_s1", 1, c, v1_o, tag1_o, res1_o);
      thr_chk("thr_s2", 2, c, valid_o, rob_tag_o, result_o);
      thr_chk("thr_s4", 4, c, v4_o, tag4_o, res4_o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
